// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus responder and its storage.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_BOTH,
        ERR_ALIGN,
        ERR_RANGE
    } err_cause_t;

endpackage

// File: rtl/mem_bus_ram.sv
// Word-addressed backing store: byte-lane synchronous write, registered read.
module mem_bus_ram
    import mem_bus_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                      clk,
    input  logic [AW-1:0]             addr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [BYTES_PER_WORD-1:0] we,
    input  logic                      re,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem [DEPTH_WORDS];

    // rdata only moves on re, so it holds the last read word between reads
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Wait-state memory bus responder: accepts one request, responds after
// WAIT_CYCLES wait states with a one-cycle ready strobe.
//
// state | meaning
// IDLE  | waiting for a read or write request; latches it on accept
// WAIT  | counting wait states down to zero
// RESP  | bus_ready high for one cycle; write commits on the exit edge
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          bus_addr_in,
    input  logic [WIDTH-1:0]          bus_data_in,
    input  logic [BYTES_PER_WORD-1:0] bus_byteen,
    input  logic                      bus_mem_read,
    input  logic                      bus_mem_write,
    output logic [WIDTH-1:0]          bus_data_out,
    output logic                      bus_ready,
    output logic                      bus_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [WIDTH-1:0] MEM_BYTES = WIDTH'(DEPTH_WORDS * BYTES_PER_WORD);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                    state;
    logic [3:0]                cnt;
    logic [AW-1:0]             addr_q;
    logic [WIDTH-1:0]          wdata_q;
    logic [BYTES_PER_WORD-1:0] byteen_q;
    logic                      rd_q;
    logic                      wr_q;
    err_cause_t                cause_q;
    logic                      ready_q;
    logic                      err_q;
    logic                      data_valid_q;

    err_cause_t                cause_in;
    err_cause_t                resp_cause;
    logic                      accept;
    logic                      go_resp;
    logic                      resp_read;
    logic [AW-1:0]             ram_addr;
    logic                      ram_re;
    logic [BYTES_PER_WORD-1:0] ram_we;
    logic [WIDTH-1:0]          ram_rdata;

    always_comb begin
        cause_in = ERR_NONE;
        if (bus_mem_read && bus_mem_write) begin
            cause_in = ERR_BOTH;
        end else if (bus_addr_in[1:0] != 2'b00) begin
            cause_in = ERR_ALIGN;
        end else if (bus_addr_in >= MEM_BYTES) begin
            cause_in = ERR_RANGE;
        end
    end

    // With zero wait states the response follows accept directly, so the
    // read must be issued from the live inputs rather than the latches.
    assign accept     = (state == IDLE) && (bus_mem_read || bus_mem_write);
    assign go_resp    = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd0));
    assign resp_cause = (state == IDLE) ? cause_in : cause_q;
    assign resp_read  = (state == IDLE) ? bus_mem_read : rd_q;
    assign ram_addr   = (state == IDLE) ? bus_addr_in[AW+1:2] : addr_q;
    assign ram_re     = go_resp && resp_read && (resp_cause == ERR_NONE) && !reset;
    assign ram_we     = ((state == RESP) && wr_q && (cause_q == ERR_NONE) && !reset)
                        ? byteen_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            ready_q <= go_resp;
            err_q   <= go_resp && (resp_cause != ERR_NONE);
            if (go_resp && (resp_cause != ERR_NONE)) begin
                data_valid_q <= 1'b0;
            end else if (ram_re) begin
                data_valid_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q   <= bus_addr_in[AW+1:2];
                        wdata_q  <= bus_data_in;
                        byteen_q <= bus_byteen;
                        rd_q     <= bus_mem_read;
                        wr_q     <= bus_mem_write;
                        cause_q  <= cause_in;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    mem_bus_ram #(
        .WIDTH       (WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .we    (ram_we),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    assign bus_ready    = ready_q;
    assign bus_err      = err_q;
    assign bus_data_out = data_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench: one responder with two wait states, one with none.
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr_r  [2];
    logic [31:0] data_r  [2];
    logic [3:0]  be_r    [2];
    logic        rd_r    [2];
    logic        wr_r    [2];
    logic [31:0] dout_w  [2];
    logic        ready_w [2];
    logic        err_w   [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_bus_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_w2 (
        .clk           (clk),
        .reset         (reset),
        .bus_addr_in   (addr_r[0]),
        .bus_data_in   (data_r[0]),
        .bus_byteen    (be_r[0]),
        .bus_mem_read  (rd_r[0]),
        .bus_mem_write (wr_r[0]),
        .bus_data_out  (dout_w[0]),
        .bus_ready     (ready_w[0]),
        .bus_err       (err_w[0])
    );

    mem_bus_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_w0 (
        .clk           (clk),
        .reset         (reset),
        .bus_addr_in   (addr_r[1]),
        .bus_data_in   (data_r[1]),
        .bus_byteen    (be_r[1]),
        .bus_mem_read  (rd_r[1]),
        .bus_mem_write (wr_r[1]),
        .bus_data_out  (dout_w[1]),
        .bus_ready     (ready_w[1]),
        .bus_err       (err_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives a request at the start of cycle 0, swaps the address to a_mid
    // in cycle 1, and drops the request in the cycle after bus_ready.
    task automatic xfer(input int u, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] a_mid,
                        input logic [31:0] d, input logic [3:0] be,
                        output int lat, output logic err, output logic [31:0] q);
        addr_r[u] = a;
        data_r[u] = d;
        be_r[u]   = be;
        rd_r[u]   = rd;
        wr_r[u]   = wr;
        lat = -1;
        err = 1'bx;
        q   = 'x;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (c == 1) addr_r[u] = a_mid;
            if (ready_w[u] === 1'b1) begin
                lat = c;
                err = err_w[u];
                q   = dout_w[u];
                break;
            end
        end
        @(posedge clk); #1;
        rd_r[u] = 1'b0;
        wr_r[u] = 1'b0;
        chk("ready_low_after_resp", 32'(ready_w[u]), 32'd0);
    endtask

    initial begin
        int          lat;
        logic        err;
        logic [31:0] q;
        int          extra;

        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            addr_r[u] = '0; data_r[u] = '0; be_r[u] = '0; rd_r[u] = 1'b0; wr_r[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready_w[0]), 32'd0);
        chk("rst_err",   32'(err_w[0]),   32'd0);
        chk("rst_dout",  dout_w[0],       32'd0);
        reset = 1'b0;

        // full write then read, two wait states
        xfer(0, 1'b0, 1'b1, 32'h10, 32'h10, 32'hDEADBEEF, 4'hF, lat, err, q);
        chk("wr10_lat", 32'(lat), 32'd3);
        chk("wr10_err", 32'(err), 32'd0);
        chk("wr10_dout_before_any_read", q, 32'd0);
        xfer(0, 1'b1, 1'b0, 32'h10, 32'h10, 32'h0, 4'h0, lat, err, q);
        chk("rd10_lat",  32'(lat), 32'd3);
        chk("rd10_err",  32'(err), 32'd0);
        chk("rd10_data", q, 32'hDEADBEEF);

        // partial write and zero-lane write
        xfer(0, 1'b0, 1'b1, 32'h20, 32'h20, 32'h11223344, 4'hF, lat, err, q);
        chk("wr20_dout_held", q, 32'hDEADBEEF);
        xfer(0, 1'b0, 1'b1, 32'h20, 32'h20, 32'h000000AA, 4'b0001, lat, err, q);
        chk("wr20_lane0_err", 32'(err), 32'd0);
        xfer(0, 1'b1, 1'b0, 32'h20, 32'h20, 32'h0, 4'h0, lat, err, q);
        chk("rd20_partial", q, 32'h112233AA);
        xfer(0, 1'b0, 1'b1, 32'h20, 32'h20, 32'hFFFFFFFF, 4'b0000, lat, err, q);
        chk("wr20_nolane_lat", 32'(lat), 32'd3);
        chk("wr20_nolane_err", 32'(err), 32'd0);
        xfer(0, 1'b1, 1'b0, 32'h20, 32'h20, 32'h0, 4'h0, lat, err, q);
        chk("rd20_unchanged", q, 32'h112233AA);

        // error responses
        xfer(0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0BADF00D, 4'hF, lat, err, q);
        xfer(0, 1'b1, 1'b0, 32'h13, 32'h13, 32'h0, 4'h0, lat, err, q);
        chk("rd13_lat",  32'(lat), 32'd3);
        chk("rd13_err",  32'(err), 32'd1);
        chk("rd13_dout", q, 32'd0);
        xfer(0, 1'b0, 1'b1, 32'h1000, 32'h1000, 32'h55555555, 4'hF, lat, err, q);
        chk("wr1000_lat",  32'(lat), 32'd3);
        chk("wr1000_err",  32'(err), 32'd1);
        chk("wr1000_dout", q, 32'd0);
        xfer(0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, lat, err, q);
        chk("rd0_after_range_err", q, 32'h0BADF00D);
        xfer(0, 1'b1, 1'b1, 32'h10, 32'h10, 32'h0, 4'hF, lat, err, q);
        chk("both_lat",  32'(lat), 32'd3);
        chk("both_err",  32'(err), 32'd1);
        chk("both_dout", q, 32'd0);
        xfer(0, 1'b1, 1'b0, 32'h10, 32'h10, 32'h0, 4'h0, lat, err, q);
        chk("rd10_after_both", q, 32'hDEADBEEF);
        chk("rd10_after_both_err", 32'(err), 32'd0);

        // address changed during WAIT is ignored
        xfer(0, 1'b1, 1'b0, 32'h10, 32'h20, 32'h0, 4'h0, lat, err, q);
        chk("addr_change_data", q, 32'hDEADBEEF);

        // zero wait states: back-to-back reads, no duplicate response
        xfer(1, 1'b0, 1'b1, 32'h0, 32'h0, 32'hA0A0A0A0, 4'hF, lat, err, q);
        chk("w0_wr0_lat", 32'(lat), 32'd1);
        xfer(1, 1'b0, 1'b1, 32'h4, 32'h4, 32'h0B0B0B0B, 4'hF, lat, err, q);
        xfer(1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, lat, err, q);
        chk("w0_rd0_lat",  32'(lat), 32'd1);
        chk("w0_rd0_data", q, 32'hA0A0A0A0);
        xfer(1, 1'b1, 1'b0, 32'h4, 32'h4, 32'h0, 4'h0, lat, err, q);
        chk("w0_rd4_lat",  32'(lat), 32'd1);
        chk("w0_rd4_data", q, 32'h0B0B0B0B);
        extra = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (ready_w[1] !== 1'b0) extra++;
        end
        chk("w0_no_duplicate", 32'(extra), 32'd0);
        chk("w0_dout_hold", dout_w[1], 32'h0B0B0B0B);
        xfer(1, 1'b1, 1'b0, 32'h2, 32'h2, 32'h0, 4'h0, lat, err, q);
        chk("w0_rd2_lat",  32'(lat), 32'd1);
        chk("w0_rd2_err",  32'(err), 32'd1);
        chk("w0_rd2_dout", q, 32'd0);

        // reset in WAIT aborts a write
        xfer(0, 1'b0, 1'b1, 32'h40, 32'h40, 32'h12345678, 4'hF, lat, err, q);
        xfer(0, 1'b1, 1'b0, 32'h10, 32'h10, 32'h0, 4'h0, lat, err, q);
        chk("pre_reset_dout", q, 32'hDEADBEEF);
        addr_r[0] = 32'h40;
        data_r[0] = 32'hCAFEF00D;
        be_r[0]   = 4'hF;
        wr_r[0]   = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", 32'(ready_w[0]), 32'd0);
        chk("abort_err",   32'(err_w[0]),   32'd0);
        chk("abort_dout",  dout_w[0],       32'd0);
        wr_r[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("abort_ready_hold", 32'(ready_w[0]), 32'd0);
        end
        reset = 1'b0;
        xfer(0, 1'b1, 1'b0, 32'h40, 32'h40, 32'h0, 4'h0, lat, err, q);
        chk("post_reset_lat",  32'(lat), 32'd3);
        chk("post_reset_err",  32'(err), 32'd0);
        chk("post_reset_data", q, 32'h12345678);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
